bomb_game_ctrl: RTL

Top-level game controller for the bomb-defusal timer. It sequences the three-digit BCD countdown datapath: loads the start time, generates the gated one-second tick, and counts wrong-code strikes. It decides the DEFUSED or EXPLODED outcome from code-entry results and the countdown's zero flag. It sits between the keypad/code checker and the countdown/display path.

---
 rtl/bomb_pkg.sv | 18 +
 rtl/bomb_game_ctrl_if.sv | 28 ++
 rtl/bomb_game_ctrl_tick_gen.sv | 50 +++++
 rtl/bomb_game_ctrl.sv | 115 +++++++++++
 4 files changed

// File: rtl/bomb_pkg.sv
// Shared types and defaults for the bomb-defusal game controller.
package bomb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ARMED     = 3'd1,
    ST_COUNTING  = 3'd2,
    ST_DEFUSED   = 3'd3,
    ST_EXPLODED  = 3'd4
  } game_state_t;

  typedef logic [3:0] bcd_t;

  localparam logic [11:0] START_TIME_DEF  = 12'h300;
  localparam int          MAX_STRIKES_DEF = 3;
  localparam int          TICK_DIV_DEF    = 50_000_000;

endpackage

// File: rtl/bomb_game_ctrl_if.sv
// Keypad/code-checker and countdown/display signals of the game controller.
interface bomb_game_ctrl_if;
  import bomb_pkg::*;

  logic             start_btn;
  logic             code_valid;
  logic             code_ok;
  logic             cnt_zero;
  logic             cnt_load;
  bcd_t [2:0]       cnt_init;
  logic             cnt_run;
  logic             sec_tick;
  logic [1:0]       strikes;
  logic [2:0]       state_o;
  logic             defused;
  logic             exploded;

  modport master (
    output start_btn, code_valid, code_ok, cnt_zero,
    input  cnt_load, cnt_init, cnt_run, sec_tick, strikes, state_o, defused, exploded
  );

  modport slave (
    input  start_btn, code_valid, code_ok, cnt_zero,
    output cnt_load, cnt_init, cnt_run, sec_tick, strikes, state_o, defused, exploded
  );

endinterface

// File: rtl/bomb_game_ctrl_tick_gen.sv
// Prescaler that emits a registered one-cycle tick every TICK_DIV enabled cycles.
module tick_gen #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] count_q, count_d;
  logic          tick_q, tick_d;

  // Next prescaler value; clear wins over enable so no tick leaks past an exit.
  always_comb begin
    count_d = count_q;
    tick_d  = 1'b0;
    if (clr) begin
      count_d = {CW{1'b0}};
    end else if (en) begin
      if (count_q == LAST) begin
        count_d = {CW{1'b0}};
        tick_d  = 1'b1;
      end else begin
        count_d = count_q + ONE;
      end
    end else begin
      count_d = count_q;
    end
  end

  // Prescaler and tick registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= {CW{1'b0}};
      tick_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      tick_q  <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/bomb_game_ctrl.sv
// Game controller: start/arm sequencing, strike counting and DEFUSED/EXPLODED outcome.
module bomb_game_ctrl
  import bomb_pkg::*;
#(
  parameter int          TICK_DIV    = TICK_DIV_DEF,
  parameter logic [11:0] START_TIME  = START_TIME_DEF,
  parameter int          MAX_STRIKES = MAX_STRIKES_DEF
) (
  input  logic             clk,
  input  logic             reset,
  bomb_game_ctrl_if.slave  bus
);

  localparam logic [1:0] STRIKE_LIMIT = 2'(MAX_STRIKES);
  localparam logic [1:0] LAST_STRIKE  = 2'(MAX_STRIKES - 1);

  game_state_t state_q, state_d;
  logic [1:0]  strikes_q, strikes_d;
  logic        cnt_load_q, cnt_load_d;
  logic        cnt_run_q, cnt_run_d;
  logic        tick_en;
  logic        tick_clr;
  logic        tick;

  // State and registered-output flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      strikes_q  <= 2'd0;
      cnt_load_q <= 1'b0;
      cnt_run_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      strikes_q  <= strikes_d;
      cnt_load_q <= cnt_load_d;
      cnt_run_q  <= cnt_run_d;
    end
  end

  // Next-state and strike logic; timeout outranks any code result.
  always_comb begin
    state_d   = state_q;
    strikes_d = strikes_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start_btn) begin
          state_d   = ST_ARMED;
          strikes_d = 2'd0;
        end else begin
          state_d   = ST_IDLE;
        end
      end
      ST_ARMED: begin
        state_d = ST_COUNTING;
      end
      ST_COUNTING: begin
        if (bus.cnt_zero) begin
          state_d = ST_EXPLODED;
        end else if (bus.code_valid && !bus.code_ok) begin
          if (strikes_q < STRIKE_LIMIT) begin
            strikes_d = strikes_q + 2'd1;
          end else begin
            strikes_d = strikes_q;
          end
          if (strikes_q == LAST_STRIKE) begin
            state_d = ST_EXPLODED;
          end else begin
            state_d = ST_COUNTING;
          end
        end else if (bus.code_valid) begin
          state_d = ST_DEFUSED;
        end else begin
          state_d = ST_COUNTING;
        end
      end
      ST_DEFUSED, ST_EXPLODED: begin
        if (bus.start_btn) begin
          state_d = ST_IDLE;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode; cnt_run/cnt_load look ahead one state so they arrive registered.
  always_comb begin
    cnt_load_d   = (state_q == ST_IDLE) && bus.start_btn;
    cnt_run_d    = (state_d == ST_COUNTING);
    tick_en      = (state_q == ST_COUNTING);
    tick_clr     = (state_d != ST_COUNTING);
    bus.cnt_load = cnt_load_q;
    bus.cnt_run  = cnt_run_q;
    bus.sec_tick = tick;
    bus.strikes  = strikes_q;
    bus.state_o  = state_q;
    bus.defused  = (state_q == ST_DEFUSED);
    bus.exploded = (state_q == ST_EXPLODED);
    bus.cnt_init = START_TIME;
  end

  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .en    (tick_en),
    .clr   (tick_clr),
    .tick  (tick)
  );

endmodule
